// File: rtl/fpu_issue_ctl.sv
`default_nettype none
// fpu_issue_ctl: issues one FP request at a time onto the fpu core buses, tracks
// completion through fpbusyn and returns the result on a valid/ready port. Rev 1.0
module fpu_issue_ctl #(
   parameter int WDOG_W = 8
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_op,
   input  logic        req_dprec,
   input  logic        req_res2,
   input  logic [31:0] req_a_hi,
   input  logic [31:0] req_a_lo,
   input  logic [31:0] req_b_hi,
   input  logic [31:0] req_b_lo,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_hi,
   output logic [31:0] rsp_lo,
   output logic        rsp_tmo,
   input  logic        iu_kill,
   input  logic        iu_hold,
   output logic [7:0]  fpop,
   output logic        fpop_valid,
   output logic [31:0] fpain,
   output logic [31:0] fpbin,
   output logic        fpkill,
   output logic        fphold,
   input  logic [31:0] fpout,
   input  logic        fpbusyn
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_OPND2 = 3'd2,
      S_WAIT  = 3'd3,
      S_RES2  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               dprec_q, dprec_d;
   logic               res2_q, res2_d;
   logic [31:0]        a_lo_q, a_lo_d;
   logic [31:0]        b_lo_q, b_lo_d;
   logic [7:0]         fpop_q, fpop_d;
   logic [31:0]        fpain_q, fpain_d;
   logic [31:0]        fpbin_q, fpbin_d;
   logic [31:0]        rsp_hi_q, rsp_hi_d;
   logic [31:0]        rsp_lo_q, rsp_lo_d;
   logic               rsp_tmo_q, rsp_tmo_d;
   logic               seen_busy_q, seen_busy_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;

   logic               w_idle;
   logic               w_wdog_max;

   assign w_idle     = (state_q == S_IDLE);
   assign w_wdog_max = &wdog_q;

   assign fpop    = fpop_q;
   assign fpain   = fpain_q;
   assign fpbin   = fpbin_q;
   assign rsp_hi  = rsp_hi_q;
   assign rsp_lo  = rsp_lo_q;
   assign rsp_tmo = rsp_tmo_q;
   assign fphold  = iu_hold;

   always_comb begin
      state_d     = state_q;
      dprec_d     = dprec_q;
      res2_d      = res2_q;
      a_lo_d      = a_lo_q;
      b_lo_d      = b_lo_q;
      fpop_d      = fpop_q;
      fpain_d     = fpain_q;
      fpbin_d     = fpbin_q;
      rsp_hi_d    = rsp_hi_q;
      rsp_lo_d    = rsp_lo_q;
      rsp_tmo_d   = rsp_tmo_q;
      seen_busy_d = seen_busy_q;
      wdog_d      = wdog_q;

      // Ready is withheld under hold as well, so a handshake always means accept.
      req_ready  = w_idle && !iu_kill && !iu_hold;
      fpop_valid = (state_q == S_ISSUE);
      rsp_valid  = (state_q == S_DONE);
      fpkill     = (!w_idle && iu_kill) ||
                   ((state_q == S_WAIT) && w_wdog_max && !iu_hold);

      if (!w_idle && iu_kill) begin
         state_d     = S_IDLE;
         rsp_tmo_d   = 1'b0;
         seen_busy_d = 1'b0;
         wdog_d      = '0;
      end else if (!iu_hold) begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && !iu_kill) begin
                  fpop_d  = req_op;
                  fpain_d = req_a_hi;
                  fpbin_d = req_b_hi;
                  dprec_d = req_dprec;
                  res2_d  = req_res2;
                  a_lo_d  = req_a_lo;
                  b_lo_d  = req_b_lo;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (dprec_q) begin
                  fpain_d = a_lo_q;
                  fpbin_d = b_lo_q;
                  state_d = S_OPND2;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_OPND2: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // The watchdog wins over a simultaneous completion so that no
               // output ever depends combinationally on fpbusyn.
               if (w_wdog_max) begin
                  rsp_hi_d  = '0;
                  rsp_lo_d  = '0;
                  rsp_tmo_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  wdog_d = wdog_q + WDOG_W'(1);
                  if (!fpbusyn) begin
                     seen_busy_d = 1'b1;
                  end
                  if (fpbusyn && seen_busy_q) begin
                     rsp_hi_d = fpout;
                     rsp_lo_d = '0;
                     state_d  = res2_q ? S_RES2 : S_DONE;
                  end
               end
            end
            S_RES2: begin
               rsp_lo_d = fpout;
               state_d  = S_DONE;
            end
            S_DONE: begin
               if (rsp_ready) begin
                  rsp_tmo_d   = 1'b0;
                  seen_busy_d = 1'b0;
                  wdog_d      = '0;
                  state_d     = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= S_IDLE;
         dprec_q     <= 1'b0;
         res2_q      <= 1'b0;
         a_lo_q      <= '0;
         b_lo_q      <= '0;
         fpop_q      <= '0;
         fpain_q     <= '0;
         fpbin_q     <= '0;
         rsp_hi_q    <= '0;
         rsp_lo_q    <= '0;
         rsp_tmo_q   <= 1'b0;
         seen_busy_q <= 1'b0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         dprec_q     <= dprec_d;
         res2_q      <= res2_d;
         a_lo_q      <= a_lo_d;
         b_lo_q      <= b_lo_d;
         fpop_q      <= fpop_d;
         fpain_q     <= fpain_d;
         fpbin_q     <= fpbin_d;
         rsp_hi_q    <= rsp_hi_d;
         rsp_lo_q    <= rsp_lo_d;
         rsp_tmo_q   <= rsp_tmo_d;
         seen_busy_q <= seen_busy_d;
         wdog_q      <= wdog_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctl.sv
`default_nettype none
// tb_fpu_issue_ctl: directed and randomized sequences checked against a
// per-operation expected trace built from the issue/wait/response rules.
module tb_fpu_issue_ctl;

   localparam int WDOG_W   = 4;
   localparam int WDOG_LIM = (1 << WDOG_W) - 1;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        req_valid, req_ready;
   logic [7:0]  req_op;
   logic        req_dprec, req_res2;
   logic [31:0] req_a_hi, req_a_lo, req_b_hi, req_b_lo;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_hi, rsp_lo;
   logic        rsp_tmo;
   logic        iu_kill, iu_hold;
   logic [7:0]  fpop;
   logic        fpop_valid;
   logic [31:0] fpain, fpbin;
   logic        fpkill, fphold;
   logic [31:0] fpout;
   logic        fpbusyn;

   always #5 clk = ~clk;

   fpu_issue_ctl #(.WDOG_W(WDOG_W)) dut (
      .clk(clk), .reset_l(reset_l),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_dprec(req_dprec), .req_res2(req_res2),
      .req_a_hi(req_a_hi), .req_a_lo(req_a_lo), .req_b_hi(req_b_hi), .req_b_lo(req_b_lo),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
      .rsp_tmo(rsp_tmo), .iu_kill(iu_kill), .iu_hold(iu_hold),
      .fpop(fpop), .fpop_valid(fpop_valid), .fpain(fpain), .fpbin(fpbin),
      .fpkill(fpkill), .fphold(fphold), .fpout(fpout), .fpbusyn(fpbusyn)
   );

   typedef struct {
      logic        pv;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        busyn;
      logic [31:0] fo;
      logic        wdk;
      logic        rv;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        tmo;
      logic        last;
   } step_t;

   int          n_checks = 0;
   int          n_err    = 0;
   int          op_no    = 0;
   logic [7:0]  e_op;
   logic [31:0] e_a, e_b;

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance to posedge+1.
   task automatic cyc(input string ph, input logic hold, input logic kill, input logic rqv,
                      input logic rsr, input logic busyn, input logic [31:0] fo,
                      input logic x_rr, input logic x_pv, input logic x_fk, input logic x_rv,
                      input logic [31:0] x_hi, input logic [31:0] x_lo, input logic x_tmo);
      iu_hold = hold; iu_kill = kill; req_valid = rqv; rsp_ready = rsr;
      fpbusyn = busyn; fpout = fo;
      #4;
      chk1($sformatf("%s.req_ready", ph), req_ready, x_rr);
      chk1($sformatf("%s.fpop_valid", ph), fpop_valid, x_pv);
      chk32($sformatf("%s.fpop", ph), {24'd0, fpop}, {24'd0, e_op});
      chk32($sformatf("%s.fpain", ph), fpain, e_a);
      chk32($sformatf("%s.fpbin", ph), fpbin, e_b);
      chk1($sformatf("%s.fpkill", ph), fpkill, x_fk);
      chk1($sformatf("%s.fphold", ph), fphold, hold);
      chk1($sformatf("%s.rsp_valid", ph), rsp_valid, x_rv);
      chk1($sformatf("%s.rsp_tmo", ph), rsp_tmo, x_rv & x_tmo);
      if (x_rv) begin
         chk32($sformatf("%s.rsp_hi", ph), rsp_hi, x_hi);
         chk32($sformatf("%s.rsp_lo", ph), rsp_lo, x_lo);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_cyc(input logic hold, input logic kill, input logic rqv);
      cyc($sformatf("op%0d.idle", op_no), hold, kill, rqv, 1'($urandom), 1'($urandom),
          $urandom, !kill && !hold, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic chk_reset_vals(input string ph);
      chk1({ph, ".req_ready"}, req_ready, 1'b1);
      chk1({ph, ".fpop_valid"}, fpop_valid, 1'b0);
      chk32({ph, ".fpop"}, {24'd0, fpop}, 32'd0);
      chk32({ph, ".fpain"}, fpain, 32'd0);
      chk32({ph, ".fpbin"}, fpbin, 32'd0);
      chk1({ph, ".fpkill"}, fpkill, 1'b0);
      chk1({ph, ".rsp_valid"}, rsp_valid, 1'b0);
      chk32({ph, ".rsp_hi"}, rsp_hi, 32'd0);
      chk32({ph, ".rsp_lo"}, rsp_lo, 32'd0);
      chk1({ph, ".rsp_tmo"}, rsp_tmo, 1'b0);
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
   task automatic do_reset();
      iu_hold = 1'b0; iu_kill = 1'b0; req_valid = 1'b0;
      #2; reset_l = 1'b0; #1;
      e_op = '0; e_a = '0; e_b = '0;
      chk_reset_vals("midop_reset");
      @(posedge clk); #3; reset_l = 1'b1;
      @(posedge clk); #1;
   endtask

   // Builds the expected trace of one operation, then plays it with holds,
   // an optional kill (kidx, -2 = first response cycle) or reset (ridx).
   task automatic run_op(input logic [7:0] op, input logic dprec, input logic res2,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic [31:0] bhi, input logic [31:0] blo,
                         input logic [31:0] rhi, input logic [31:0] rlo,
                         input int lat, input int dly, input int hmode,
                         input int kidx, input int ridx);
      step_t q[$];
      step_t s;
      logic  is_tmo;
      int    nw, wait0, done0, k;
      op_no++;
      is_tmo = (lat >= WDOG_LIM);
      wait0  = dprec ? 2 : 1;
      nw     = is_tmo ? WDOG_LIM + 1 : lat + 1;
      done0  = wait0 + nw + ((res2 && !is_tmo) ? 1 : 0);
      if (kidx == -2) kidx = done0;

      s = '{default: '0};
      s.pv = 1'b1; s.op = op; s.a = ahi; s.b = bhi; s.busyn = 1'b1; s.fo = $urandom;
      q.push_back(s);
      s.pv = 1'b0;
      if (dprec) begin
         s.a = alo; s.b = blo; s.fo = $urandom;
         q.push_back(s);
      end
      for (int w = 0; w < nw; w++) begin
         s.busyn = (w >= lat);
         s.fo    = (w == lat) ? rhi : $urandom;
         s.wdk   = is_tmo && (w == WDOG_LIM);
         q.push_back(s);
      end
      s.wdk = 1'b0;
      if (res2 && !is_tmo) begin
         s.busyn = 1'($urandom); s.fo = rlo;
         q.push_back(s);
      end
      s.rv  = 1'b1;
      s.hi  = is_tmo ? 32'd0 : rhi;
      s.lo  = (is_tmo || !res2) ? 32'd0 : rlo;
      s.tmo = is_tmo;
      for (int d = 0; d <= dly; d++) begin
         s.busyn = 1'($urandom); s.fo = $urandom; s.last = (d == dly);
         q.push_back(s);
      end

      if (hmode == 1) begin
         repeat ($urandom_range(0, 2)) begin
            k = int'($urandom_range(0, 2));
            idle_cyc(k != 1, k != 0, 1'b1);
         end
      end
      req_op = op; req_dprec = dprec; req_res2 = res2;
      req_a_hi = ahi; req_a_lo = alo; req_b_hi = bhi; req_b_lo = blo;
      cyc($sformatf("op%0d.accept", op_no), 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom),
          $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      req_op = 8'($urandom); req_dprec = 1'($urandom); req_res2 = 1'($urandom);
      req_a_hi = $urandom; req_a_lo = $urandom; req_b_hi = $urandom; req_b_lo = $urandom;

      foreach (q[i]) begin
         int   nh;
         logic kl, hk, rsr;
         e_op = q[i].op; e_a = q[i].a; e_b = q[i].b;
         if (i == ridx) begin
            do_reset();
            return;
         end
         if (hmode == 1)      nh = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
         else if (hmode == 2) nh = (i == 0 || i == wait0 + 1) ? 4 : 0;
         else                 nh = 0;
         repeat (nh)
            cyc($sformatf("op%0d.hold%0d", op_no, i), 1'b1, 1'b0, 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, 1'b0, q[i].pv, 1'b0, q[i].rv, q[i].hi, q[i].lo, q[i].tmo);
         kl  = (i == kidx);
         hk  = kl ? 1'($urandom) : 1'b0;
         rsr = q[i].rv ? q[i].last : 1'($urandom);
         cyc($sformatf("op%0d.s%0d", op_no, i), hk, kl, 1'($urandom), rsr, q[i].busyn, q[i].fo,
             1'b0, q[i].pv, kl | q[i].wdk, q[i].rv, q[i].hi, q[i].lo, q[i].tmo);
         if (kl) return;
      end
   endtask

   initial begin
      reset_l = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; iu_kill = 1'b0; iu_hold = 1'b0;
      req_op = '0; req_dprec = 1'b0; req_res2 = 1'b0;
      req_a_hi = '0; req_a_lo = '0; req_b_hi = '0; req_b_lo = '0;
      fpout = '0; fpbusyn = 1'b1;
      e_op = '0; e_a = '0; e_b = '0;
      #2;
      chk_reset_vals("por");
      iu_hold = 1'b1; #1;
      chk1("por.fphold", fphold, 1'b1);
      iu_hold = 1'b0;
      @(posedge clk); #3; reset_l = 1'b1;
      @(posedge clk); #1;
      idle_cyc(1'b0, 1'b0, 1'b0);
      idle_cyc(1'b0, 1'b1, 1'b1);

      // single-precision fadd, one-word result
      run_op(8'h62, 1'b0, 1'b0, 32'h3F800000, 32'hDEADBEEF, 32'h40000000, 32'hCAFEF00D,
             32'h40400000, 32'h12345678, 3, 1, 0, -1, -1);
      // double dmul, two-word result, back-to-back
      run_op(8'h6B, 1'b1, 1'b1, 32'h3FF80000, 32'h00000000, 32'h40000000, 32'h00000000,
             32'h40080000, 32'h00000000, 3, 0, 0, -1, -1);
      // 4-cycle holds in ISSUE and WAIT
      run_op(8'h62, 1'b0, 1'b0, 32'h3F800000, 32'h0, 32'h40000000, 32'h0,
             32'h40400000, 32'h0, 4, 1, 2, -1, -1);
      run_op(8'h6B, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             32'h55555555, 32'h66666666, 5, 1, 2, -1, -1);
      // kill in WAIT, then kill in DONE while not consumed
      run_op(8'h63, 1'b1, 1'b1, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0,
             32'h0BAD0BAD, 32'h0BADF00D, 6, 1, 0, 3, -1);
      idle_cyc(1'b0, 1'b0, 1'b0);
      run_op(8'h66, 1'b0, 1'b0, 32'h01020304, 32'h0, 32'h05060708, 32'h0,
             32'h090A0B0C, 32'h0, 2, 3, 0, -2, -1);
      idle_cyc(1'b0, 1'b0, 1'b0);
      run_op(8'h62, 1'b0, 1'b0, 32'h40A00000, 32'h0, 32'h3F800000, 32'h0,
             32'h40C00000, 32'h0, 2, 0, 0, -1, -1);
      // watchdog: FPU never finishes
      run_op(8'h6F, 1'b1, 1'b1, 32'h7F800000, 32'h1, 32'h7F800000, 32'h2,
             32'hFFFFFFFF, 32'hEEEEEEEE, 40, 2, 0, -1, -1);
      run_op(8'h6E, 1'b0, 1'b1, 32'h12121212, 32'h0, 32'h34343434, 32'h0,
             32'h56565656, 32'h78787878, 40, 1, 1, -1, -1);
      // asynchronous reset in the middle of WAIT
      run_op(8'h62, 1'b0, 1'b0, 32'h3F800000, 32'h0, 32'h40000000, 32'h0,
             32'h40400000, 32'h0, 20, 1, 0, -1, 4);
      idle_cyc(1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int kx;
         kx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_op(8'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, int'($urandom_range(1, 17)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), kx, -1);
         repeat ($urandom_range(0, 2)) idle_cyc(1'($urandom), 1'($urandom), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
